// File: rtl/fifo_burst_reader.sv
// Burst consumer for a fifo read port: pops i_cmdLen+1 words and streams each
// one out LSB-chunk-first as OUT_W-bit chunks, marking the final chunk with o_last.
module fifo_burst_reader #(
  parameter int WIDTH = 32,
  parameter int OUT_W = 8,
  parameter int LEN_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cg,
  input  logic             i_flush,
  input  logic [LEN_W-1:0] i_cmdLen,
  input  logic             i_cmdValid,
  output logic             o_cmdReady,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [OUT_W-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_last,
  output logic             o_busy,
  output logic [LEN_W-1:0] o_wordsLeft
);

  localparam int RATIO = WIDTH / OUT_W;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] words_left_q, words_left_d;
  logic [IDX_W-1:0] chunk_idx_q, chunk_idx_d;
  logic [WIDTH-1:0] shift_q, shift_d;

  logic flush_s, last_chunk_s, words_zero_s, cmd_acc_s, pop_s, take_s;

  assign flush_s      = i_cg & i_flush;
  assign last_chunk_s = (chunk_idx_q == IDX_LAST);
  assign words_zero_s = (words_left_q == '0);

  // The direct pop on the last chunk lets i_ready reach o_ready combinationally,
  // which is what keeps back-to-back words bubble-free.
  assign o_cmdReady  = i_rst_n & (state_q == IDLE) & i_cg & ~i_flush;
  assign o_ready     = i_cg & ~i_flush &
                       ((state_q == LOAD) |
                        ((state_q == SHIFT) & last_chunk_s & ~words_zero_s & i_ready));
  assign o_valid     = (state_q == SHIFT) & ~flush_s;
  assign o_data      = shift_q[OUT_W-1:0];
  assign o_last      = (state_q == SHIFT) & last_chunk_s & words_zero_s;
  assign o_busy      = (state_q != IDLE);
  assign o_wordsLeft = words_left_q;

  assign cmd_acc_s = i_cg & i_cmdValid & o_cmdReady;
  assign pop_s     = o_ready & i_valid;
  assign take_s    = i_cg & o_valid & i_ready;

  // State, counter and shift-register update.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      words_left_q <= '0;
      chunk_idx_q  <= '0;
      shift_q      <= '0;
    end else begin
      state_q      <= state_d;
      words_left_q <= words_left_d;
      chunk_idx_q  <= chunk_idx_d;
      shift_q      <= shift_d;
    end
  end

  // Next-state logic; flush overrides every handshake.
  always_comb begin
    state_d      = state_q;
    words_left_d = words_left_q;
    chunk_idx_d  = chunk_idx_q;
    shift_d      = shift_q;
    if (flush_s) begin
      state_d      = IDLE;
      words_left_d = '0;
      chunk_idx_d  = '0;
      shift_d      = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_acc_s) begin
            words_left_d = i_cmdLen;
            state_d      = LOAD;
          end else begin
            state_d = IDLE;
          end
        end
        LOAD: begin
          if (pop_s) begin
            shift_d     = i_data;
            chunk_idx_d = '0;
            state_d     = SHIFT;
          end else begin
            state_d = LOAD;
          end
        end
        SHIFT: begin
          if (!take_s) begin
            state_d = SHIFT;
          end else if (!last_chunk_s) begin
            shift_d     = shift_q >> OUT_W;
            chunk_idx_d = chunk_idx_q + IDX_W'(1);
          end else if (words_zero_s) begin
            state_d = IDLE;
          end else begin
            words_left_d = words_left_q - LEN_W'(1);
            if (pop_s) begin
              shift_d     = i_data;
              chunk_idx_d = '0;
              state_d     = SHIFT;
            end else begin
              state_d = LOAD;
            end
          end
        end
        default: begin
          state_d      = IDLE;
          words_left_d = '0;
          chunk_idx_d  = '0;
          shift_d      = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench for fifo_burst_reader: a queue-based fifo model feeds the
// DUT and every burst's chunk stream is compared to one derived from the words.
module tb_fifo_burst_reader;

  localparam int WIDTH = 32;
  localparam int OUT_W = 8;
  localparam int LEN_W = 8;
  localparam int RATIO = WIDTH / OUT_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, i_cg, i_flush, i_cmdValid, i_valid, i_ready;
  logic [LEN_W-1:0] i_cmdLen;
  logic [WIDTH-1:0] i_data;
  logic             o_cmdReady, o_ready, o_valid, o_last, o_busy;
  logic [OUT_W-1:0] o_data;
  logic [LEN_W-1:0] o_wordsLeft;

  logic       r1_cg, r1_flush, r1_cmdValid, r1_valid, r1_ready;
  logic [7:0] r1_cmdLen, r1_data;
  logic       r1_cmdReady, r1_oready, r1_ovalid, r1_last, r1_busy;
  logic [7:0] r1_odata, r1_wl;

  fifo_burst_reader #(.WIDTH(WIDTH), .OUT_W(OUT_W), .LEN_W(LEN_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cg(i_cg), .i_flush(i_flush),
    .i_cmdLen(i_cmdLen), .i_cmdValid(i_cmdValid), .o_cmdReady(o_cmdReady),
    .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_last(o_last), .o_busy(o_busy), .o_wordsLeft(o_wordsLeft));

  fifo_burst_reader #(.WIDTH(8), .OUT_W(8), .LEN_W(8)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_cg(r1_cg), .i_flush(r1_flush),
    .i_cmdLen(r1_cmdLen), .i_cmdValid(r1_cmdValid), .o_cmdReady(r1_cmdReady),
    .i_data(r1_data), .i_valid(r1_valid), .o_ready(r1_oready),
    .o_data(r1_odata), .o_valid(r1_ovalid), .i_ready(r1_ready),
    .o_last(r1_last), .o_busy(r1_busy), .o_wordsLeft(r1_wl));

  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] sent_q[$];
  logic [OUT_W-1:0] out_q[$];
  logic [OUT_W-1:0] exp_q[$];
  bit               last_q[$];
  bit               exp_last_q[$];
  int               take_cyc_q[$];
  logic [LEN_W-1:0] wl_q[$];
  int  checks = 0, errors = 0;
  int  cyc = 0, pop_cnt = 0, stall_err = 0, idle_ready_err = 0;
  bit  rand_ready = 1'b0, rand_gap = 1'b0, timed_out = 1'b0;
  bit  prev_stall = 1'b0, prev_pop = 1'b0;
  logic [OUT_W-1:0] prev_data;

  // Reference: first n words, each split LSB-first; only the very last chunk is last.
  function automatic void build_expected(input int n);
    logic [WIDTH-1:0] w;
    exp_q.delete();
    exp_last_q.delete();
    for (int i = 0; i < n; i++) begin
      w = sent_q[i];
      for (int k = 0; k < RATIO; k++) begin
        exp_q.push_back(OUT_W'(w >> (OUT_W * k)));
        exp_last_q.push_back((i == n - 1) && (k == RATIO - 1));
      end
    end
  endfunction

  task automatic reset_model();
    out_q.delete(); last_q.delete(); take_cyc_q.delete(); wl_q.delete();
    sent_q.delete(); fifo_q.delete();
    pop_cnt = 0; prev_stall = 1'b0; prev_pop = 1'b0; timed_out = 1'b0;
  endtask

  task automatic push_random(input int n);
    logic [WIDTH-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      fifo_q.push_back(w);
      sent_q.push_back(w);
    end
  endtask

  // One clock of fifo model + sink monitor; handshakes are sampled mid-cycle.
  task automatic cycle();
    bit pop_s, take_s;
    if (rand_ready) i_ready = ($urandom_range(0, 1) == 1);
    i_valid = (fifo_q.size() > 0) && !(rand_gap && ($urandom_range(0, 3) == 0));
    i_data  = (fifo_q.size() > 0) ? fifo_q[0] : WIDTH'($urandom);
    @(negedge clk);
    if (prev_pop) wl_q.push_back(o_wordsLeft);
    if (prev_stall && (!o_valid || o_data !== prev_data)) stall_err++;
    if (o_ready && !o_busy) idle_ready_err++;
    pop_s  = o_ready && i_valid;
    take_s = i_cg && o_valid && i_ready;
    prev_stall = o_valid && !take_s;
    prev_data  = o_data;
    prev_pop   = pop_s;
    if (take_s) begin
      out_q.push_back(o_data);
      last_q.push_back(o_last);
      take_cyc_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (pop_s) begin
      void'(fifo_q.pop_front());
      pop_cnt++;
    end
  endtask

  task automatic do_cmd(input int len);
    i_cmdLen   = LEN_W'(len);
    i_cmdValid = 1'b1;
    cycle();
    i_cmdValid = 1'b0;
  endtask

  task automatic run_idle(input int budget);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      cycle();
      if (!o_busy) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; #2 rst_n = 1'b0; #10;
    checks++;
    if ({o_cmdReady, o_valid, o_ready, o_busy, o_last, o_data, o_wordsLeft} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want all zero",
               {o_cmdReady, o_valid, o_ready, o_busy, o_last, o_data, o_wordsLeft});
    end
    checks++;
    if ({r1_cmdReady, r1_ovalid, r1_oready, r1_busy} !== 4'd0) begin
      errors++; $display("FAIL reset_r1: got %b want 0000", {r1_cmdReady, r1_ovalid, r1_oready, r1_busy});
    end
    @(posedge clk); #1 rst_n = 1'b1; #1;
    checks++;
    if (o_cmdReady !== 1'b1) begin
      errors++; $display("FAIL reset_cmdready_after: got %b want 1", o_cmdReady);
    end
  endtask

  task automatic test_single();
    int cmd_cyc;
    reset_model();
    sent_q = '{32'hA1B2C3D4};
    fifo_q = '{32'hA1B2C3D4};
    cmd_cyc = cyc;
    do_cmd(0);
    run_idle(20);
    build_expected(1);
    checks++;
    if (timed_out || out_q.size() != 4 || pop_cnt != 1) begin
      errors++; $display("FAIL single_counts: got chunks=%0d pops=%0d timeout=%0d want 4,1,0",
                         out_q.size(), pop_cnt, timed_out);
    end
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if ({out_q[i], last_q[i], take_cyc_q[i]} !== {exp_q[i], exp_last_q[i], cmd_cyc + 2 + i}) begin
        errors++; $display("FAIL single_chunk%0d: got %h last=%0d cyc=%0d want %h last=%0d cyc=%0d",
                           i, out_q[i], last_q[i], take_cyc_q[i], exp_q[i], exp_last_q[i], cmd_cyc + 2 + i);
      end
    end
    checks++;
    if (take_cyc_q.size() == 0 || cyc != take_cyc_q[take_cyc_q.size() - 1] + 1) begin
      errors++; $display("FAIL single_idle_next: got idle at cyc %0d want one after final take", cyc);
    end
  endtask

  task automatic test_multi();
    reset_model();
    sent_q = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'hFFFFFFFF};
    fifo_q = sent_q;
    do_cmd(2);
    run_idle(40);
    checks++;
    if (timed_out || out_q.size() != 12 || pop_cnt != 3) begin
      errors++; $display("FAIL multi_counts: got chunks=%0d pops=%0d timeout=%0d want 12,3,0",
                         out_q.size(), pop_cnt, timed_out);
    end
    for (int i = 0; i < out_q.size(); i++) begin
      checks++;
      if ({out_q[i], last_q[i]} !== {8'(i), (i == 11)}) begin
        errors++; $display("FAIL multi_chunk%0d: got %h last=%0d want %h last=%0d",
                           i, out_q[i], last_q[i], 8'(i), (i == 11));
      end
    end
    checks++;
    if (out_q.size() != 12 || take_cyc_q[11] - take_cyc_q[0] != 11) begin
      errors++; $display("FAIL multi_no_gap: got chunks=%0d span mismatch want span 11", out_q.size());
    end
    checks++;
    if (!(fifo_q.size() == 1 && fifo_q[0] == 32'hFFFFFFFF)) begin
      errors++; $display("FAIL multi_leftover: got size %0d want one word FFFFFFFF", fifo_q.size());
    end
  endtask

  task automatic test_backpressure();
    reset_model();
    push_random(5);
    rand_ready = 1'b1;
    stall_err  = 0;
    do_cmd(3);
    run_idle(300);
    rand_ready = 1'b0;
    i_ready    = 1'b1;
    build_expected(4);
    checks++;
    if (timed_out || out_q.size() != exp_q.size() || pop_cnt != 4 || fifo_q.size() != 1) begin
      errors++; $display("FAIL bp_counts: got chunks=%0d pops=%0d left=%0d want 16,4,1",
                         out_q.size(), pop_cnt, fifo_q.size());
    end
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if ({out_q[i], last_q[i]} !== {exp_q[i], exp_last_q[i]}) begin
        errors++; $display("FAIL bp_chunk%0d: got %h/%0d want %h/%0d",
                           i, out_q[i], last_q[i], exp_q[i], exp_last_q[i]);
      end
    end
    checks++;
    if (stall_err != 0) begin
      errors++; $display("FAIL bp_stable: got %0d stall changes want 0", stall_err);
    end
    checks++;
    if (wl_q.size() != 4) begin
      errors++; $display("FAIL bp_wordsleft_n: got %0d samples want 4", wl_q.size());
    end
    for (int i = 0; i < wl_q.size(); i++) begin
      checks++;
      if (wl_q[i] !== LEN_W'(3 - i)) begin
        errors++; $display("FAIL bp_wordsleft%0d: got %0d want %0d", i, wl_q[i], 3 - i);
      end
    end
  endtask

  task automatic test_empty_gap();
    logic [WIDTH-1:0] w;
    reset_model();
    push_random(1);
    do_cmd(2);
    for (int i = 0; i < 20 && out_q.size() < 4; i++) cycle();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({o_valid, o_busy, o_ready, out_q.size() == 4, pop_cnt == 1} !== 5'b01111) begin
        errors++; $display("FAIL gap_load%0d: got valid=%0d busy=%0d ready=%0d chunks=%0d pops=%0d want 0,1,1,4,1",
                           i, o_valid, o_busy, o_ready, out_q.size(), pop_cnt);
      end
      cycle();
    end
    for (int i = 0; i < 3; i++) begin
      w = $urandom;
      fifo_q.push_back(w);
      sent_q.push_back(w);
    end
    run_idle(40);
    build_expected(3);
    checks++;
    if (timed_out || out_q.size() != 12 || pop_cnt != 3 || fifo_q.size() != 1) begin
      errors++; $display("FAIL gap_counts: got chunks=%0d pops=%0d left=%0d want 12,3,1",
                         out_q.size(), pop_cnt, fifo_q.size());
    end
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if ({out_q[i], last_q[i]} !== {exp_q[i], exp_last_q[i]}) begin
        errors++; $display("FAIL gap_chunk%0d: got %h want %h", i, out_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_flush();
    reset_model();
    push_random(5);
    do_cmd(3);
    for (int i = 0; i < 30 && out_q.size() < 6; i++) cycle();
    i_flush = 1'b1;
    #1;
    checks++;
    if ({o_valid, o_ready, o_cmdReady} !== 3'b000) begin
      errors++; $display("FAIL flush_forced: got %b want 000", {o_valid, o_ready, o_cmdReady});
    end
    cycle();
    i_flush = 1'b0;
    #1;
    checks++;
    if ({o_busy, o_valid, o_cmdReady, o_wordsLeft} !== {3'b001, 8'd0}) begin
      errors++; $display("FAIL flush_idle: got busy=%0d valid=%0d cmdrdy=%0d wl=%0d want 0,0,1,0",
                         o_busy, o_valid, o_cmdReady, o_wordsLeft);
    end
    for (int i = 0; i < 4; i++) cycle();
    build_expected(2);
    checks++;
    if (out_q.size() != 6 || pop_cnt != 2 || fifo_q.size() != 3) begin
      errors++; $display("FAIL flush_counts: got chunks=%0d pops=%0d left=%0d want 6,2,3",
                         out_q.size(), pop_cnt, fifo_q.size());
    end
    for (int i = 0; i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL flush_chunk%0d: got %h want %h", i, out_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    reset_model();
    push_random(5);
    do_cmd(3);
    for (int i = 0; i < 30 && out_q.size() < 6; i++) cycle();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({o_cmdReady, o_valid, o_ready, o_busy, o_last, o_data, o_wordsLeft} !== 21'd0) begin
      errors++; $display("FAIL areset_clear: got %b want all zero",
                         {o_cmdReady, o_valid, o_ready, o_busy, o_last, o_data, o_wordsLeft});
    end
    @(posedge clk); #3 rst_n = 1'b1;
    prev_stall = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({o_busy, o_cmdReady} !== 2'b01) begin
      errors++; $display("FAIL areset_recover: got busy=%0d cmdrdy=%0d want 0,1", o_busy, o_cmdReady);
    end
    for (int i = 0; i < 4; i++) cycle();
    checks++;
    if (out_q.size() != 6 || pop_cnt != 2 || fifo_q.size() != 3) begin
      errors++; $display("FAIL areset_counts: got chunks=%0d pops=%0d left=%0d want 6,2,3",
                         out_q.size(), pop_cnt, fifo_q.size());
    end
  endtask

  task automatic test_clock_gate();
    logic [OUT_W-1:0] d0;
    logic [LEN_W-1:0] wl0;
    reset_model();
    push_random(5);
    do_cmd(3);
    for (int i = 0; i < 30 && out_q.size() < 5; i++) cycle();
    d0  = o_data;
    wl0 = o_wordsLeft;
    i_cg = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if ({o_data, o_wordsLeft, o_valid, o_ready, o_cmdReady, o_busy, out_q.size() == 5, pop_cnt == 2}
          !== {d0, wl0, 4'b1001, 2'b11}) begin
        errors++; $display("FAIL cg_frozen%0d: got data=%h wl=%0d v=%0d r=%0d chunks=%0d pops=%0d want %h,%0d,1,0,5,2",
                           i, o_data, o_wordsLeft, o_valid, o_ready, out_q.size(), pop_cnt, d0, wl0);
      end
    end
    i_cg = 1'b1;
    run_idle(40);
    build_expected(4);
    checks++;
    if (timed_out || out_q.size() != 16 || pop_cnt != 4) begin
      errors++; $display("FAIL cg_counts: got chunks=%0d pops=%0d want 16,4", out_q.size(), pop_cnt);
    end
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if ({out_q[i], last_q[i]} !== {exp_q[i], exp_last_q[i]}) begin
        errors++; $display("FAIL cg_chunk%0d: got %h want %h", i, out_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_ratio1();
    logic [7:0] f1[$];
    logic [7:0] got[$];
    bit         gl[$];
    int         gc[$];
    int         pops = 0;
    bit         p, t;
    f1 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    r1_cmdLen = 8'd3; r1_cmdValid = 1'b1; r1_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      r1_valid = (f1.size() > 0);
      r1_data  = (f1.size() > 0) ? f1[0] : 8'h00;
      @(negedge clk);
      p = r1_oready && r1_valid;
      t = r1_ovalid && r1_ready;
      if (t) begin got.push_back(r1_odata); gl.push_back(r1_last); gc.push_back(c); end
      @(posedge clk); #1;
      r1_cmdValid = 1'b0;
      if (p) begin void'(f1.pop_front()); pops++; end
      if (c > 0 && !r1_busy) break;
    end
    checks++;
    if (got.size() != 4 || pops != 4 || !(f1.size() == 1 && f1[0] == 8'h55)) begin
      errors++; $display("FAIL r1_counts: got chunks=%0d pops=%0d left=%0d want 4,4,1", got.size(), pops, f1.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if ({got[i], gl[i], gc[i] == gc[0] + i} !== {8'(8'h11 * (i + 1)), (i == 3), 1'b1}) begin
        errors++; $display("FAIL r1_chunk%0d: got %h last=%0d cyc=%0d want %h last=%0d consecutive",
                           i, got[i], gl[i], gc[i], 8'(8'h11 * (i + 1)), (i == 3));
      end
    end
  endtask

  task automatic test_random();
    int len;
    rand_gap = 1'b1;
    stall_err = 0;
    for (int it = 0; it < 6; it++) begin
      reset_model();
      len = $urandom_range(0, 4);
      push_random(len + 3);
      rand_ready = ($urandom_range(0, 1) == 1);
      i_ready = 1'b1;
      do_cmd(len);
      run_idle(400);
      build_expected(len + 1);
      checks++;
      if (timed_out || out_q.size() != exp_q.size() || pop_cnt != len + 1 || fifo_q.size() != 2) begin
        errors++; $display("FAIL rand%0d_counts: got chunks=%0d pops=%0d left=%0d want %0d,%0d,2",
                           it, out_q.size(), pop_cnt, fifo_q.size(), exp_q.size(), len + 1);
      end
      for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
        checks++;
        if ({out_q[i], last_q[i]} !== {exp_q[i], exp_last_q[i]}) begin
          errors++; $display("FAIL rand%0d_chunk%0d: got %h/%0d want %h/%0d",
                             it, i, out_q[i], last_q[i], exp_q[i], exp_last_q[i]);
        end
      end
    end
    rand_gap = 1'b0;
    rand_ready = 1'b0;
    i_ready = 1'b1;
    checks++;
    if (stall_err != 0 || idle_ready_err != 0) begin
      errors++; $display("FAIL rand_invariants: got stall=%0d idle_ready=%0d want 0,0", stall_err, idle_ready_err);
    end
  endtask

  initial begin
    i_cg = 1'b1; i_flush = 1'b0; i_cmdValid = 1'b0; i_cmdLen = '0;
    i_valid = 1'b0; i_data = '0; i_ready = 1'b1;
    r1_cg = 1'b1; r1_flush = 1'b0; r1_cmdValid = 1'b0; r1_cmdLen = 8'd0;
    r1_valid = 1'b0; r1_data = 8'd0; r1_ready = 1'b1;
    prev_data = '0;
    test_reset();
    test_single();
    test_multi();
    test_backpressure();
    test_empty_gap();
    test_flush();
    test_async_reset();
    test_clock_gate();
    test_ratio1();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Consumer for the read side of a fifo.
- On a burst command it pops N+1 words of WIDTH bits from the fifo's valid/ready output, serialises each word LSB-chunk-first into OUT_W-bit chunks, and flags the final chunk of the burst with o_last.
- Sits between a fifo and a narrow streaming sink such as a UART TX or byte pipe.

Parameters:
- WIDTH, 32, upstream word width; must be a nonzero multiple of OUT_W.
- OUT_W, 8, downstream chunk width; 1 or more.
- LEN_W, 8, command length width; a burst is i_cmdLen+1 words (1..2^LEN_W).

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_cg  input  1  clock-gate enable; when low all state holds and no handshake completes.
- i_flush  input  1  synchronous abort, qualified by i_cg.
- i_cmdLen  input  LEN_W  burst length minus one.
- i_cmdValid  input  1  command request.
- o_cmdReady  output  1  command accept.
- i_data  input  WIDTH  fifo o_data.
- i_valid  input  1  fifo o_valid (!empty).
- o_ready  output  1  pop strobe to fifo i_ready.
- o_data  output  OUT_W  current chunk.
- o_valid  output  1  chunk valid.
- i_ready  input  1  sink accept.
- o_last  output  1  final chunk of burst.
- o_busy  output  1  burst in progress (state != IDLE).
- o_wordsLeft  output  LEN_W  words still to pop after the current one.

Behaviour:
- Derived values: RATIO = WIDTH/OUT_W; IDX_W = max(1, $clog2(RATIO)).
- Handshake qualifiers: cmdAcc = i_cg && i_cmdValid && o_cmdReady; pop = o_ready && i_valid; take = i_cg && o_valid && i_ready.
- State machine, 2-bit:
  - IDLE: o_cmdReady = i_cg && !i_flush. On cmdAcc: wordsLeft_q <= i_cmdLen, go to LOAD.
  - LOAD: o_ready = i_cg && !i_flush. On pop: shift_q <= i_data, chunkIdx_q <= 0, go to SHIFT.
  - SHIFT:
    - o_valid = 1; o_data = shift_q[OUT_W-1:0].
    - On take with chunkIdx_q != RATIO-1: shift_q >>= OUT_W and chunkIdx_q++.
    - On take of the last chunk (chunkIdx_q == RATIO-1):
      - if wordsLeft_q == 0: go to IDLE;
      - else wordsLeft_q-- and either go to LOAD, or, if i_valid that cycle, pop directly. In that case o_ready = i_cg && i_ready && !i_flush, so a combinational path i_ready->o_ready is permitted. On the direct pop, load shift_q <= i_data, chunkIdx_q <= 0, stay in SHIFT.
- Throughput: back-to-back words give one chunk per cycle with no bubble, including RATIO=1.
- Latency:
  - cmdAcc to first possible pop: 1 cycle.
  - pop to o_valid: 1 cycle (registered).
- o_last = (state==SHIFT) && chunkIdx_q==RATIO-1 && wordsLeft_q==0.
- o_ready is never asserted in IDLE. Words are never popped beyond the commanded count, even if the fifo holds more.
- o_valid stays high and o_data stays stable while i_ready is low.
- o_cmdReady is low in LOAD/SHIFT; a new command is accepted only in IDLE. The cycle after the final take, the block is back in IDLE.
- i_flush with i_cg, any state:
  - next state IDLE; wordsLeft_q and chunkIdx_q cleared;
  - o_ready, o_cmdReady and o_valid are forced low that cycle, so no pop, take or command completes;
  - shift_q contents are discarded. Flush has priority over every other event.
- Reset, asynchronous on i_rst_n low: state IDLE, wordsLeft_q 0, chunkIdx_q 0, shift_q 0.
  - Outputs: o_valid 0, o_ready 0, o_last 0, o_busy 0, o_wordsLeft 0, o_data 0.
  - o_cmdReady 0 while in reset; after deassertion it is 1 whenever i_cg is high.
  - Reset mid-burst abandons it; the fifo is not popped further.
- i_cg low: all registers hold; o_ready and o_cmdReady low. o_valid and o_data remain driven from held state but no take is counted.
- Arithmetic:
  - wordsLeft_q decrements only in SHIFT with wordsLeft_q > 0, so it never wraps.
  - chunkIdx_q wraps RATIO-1 -> 0 only on word reload.
  - For RATIO=1, chunkIdx_q is tied to 0 and every chunk is a word's last chunk.

Test Plan:
- Single word: i_cmdLen=0; fifo presents 0xA1B2C3D4, WIDTH=32, OUT_W=8, i_ready=1 -> exactly one pop; o_data sequence D4,C3,B2,A1 on consecutive cycles; o_last only with A1; o_busy low the next cycle.
- Multi-word streaming: i_cmdLen=2; fifo holds 0x03020100, 0x07060504, 0x0B0A0908, 0xFFFFFFFF -> 12 chunks 00..0B with no gaps; exactly 3 pops; 0xFFFFFFFF remains in the fifo; o_last with 0B.
- Backpressure: random i_ready at 50% during a 4-word burst -> o_data stable while stalled; chunk order is preserved; o_wordsLeft counts 3,2,1,0 at each word load.
- Empty fifo mid-burst: i_valid low for 5 cycles between word 1 and word 2 -> state LOAD, o_valid low, no chunk lost or duplicated; resumes when i_valid rises.
- Flush / reset: i_flush at chunk 2 of word 1 of a 4-word burst -> next cycle IDLE, o_valid=0, no further pops, o_cmdReady=1. Repeat with an async i_rst_n pulse mid-cycle -> outputs clear immediately, same recovery.
- Clock gate and RATIO=1 build (WIDTH=OUT_W=8): i_cg low for 3 cycles mid-burst -> state and counters frozen, no pop or take counted. With RATIO=1, i_cmdLen=3 and 4 words 11,22,33,44 with i_ready=1 -> output 11,22,33,44 on 4 consecutive cycles; o_last with 44.
